adc_sample_capture: RTL
=======================

# adc_sample_capture

Upstream acquisition stage for the ultrasonic capture path: paces conversions on an external serial ADC at a fixed sample rate, shifts each result in over a 3-wire SPI-style link, and presents it as a 16-bit word with a one-cycle write strobe for the sample FIFO. It replaces the free-running test counter as the FIFO data source. Samples arriving while the FIFO is full are discarded and counted.

## Interface
- DIV, 128: SYS_CLK cycles per sample period (128 at 40 MHz gives 312.5 kHz); legal range ≥ CONV_CYC + 2·SCK_HALF·BITS + 4.
- BITS, 16: bits per conversion result; also the width of DOUT.
- SCK_HALF, 2: SYS_CLK cycles per SCK half-period.
- CONV_CYC, 40: SYS_CLK cycles CONVST is held high (the ADC conversion time).

- SYS_CLK  in  1  system clock (40 MHz).
- RSTbar  in  1  asynchronous, active-low reset.
- ENA  in  1  sampling enable, synchronous to SYS_CLK.
- FIFO_FULL  in  1  downstream FIFO full flag.
- ADC_SDO  in  1  ADC serial data (MISO).
- ADC_CONVST  out  1  conversion start, active high.
- ADC_CSbar  out  1  ADC chip select, active low.
- ADC_SCK  out  1  serial clock, idle low.
- DOUT  out  BITS  last captured sample; held until the next capture.
- WR  out  1  one-cycle FIFO write strobe, valid with DOUT.
- DROPS  out  16  count of samples discarded because of FIFO_FULL; saturates at 0xFFFF.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Reset (async assert, sync release): state IDLE, period counter 0, DOUT=0, WR=0, DROPS=0, BUSY=0, ADC_CONVST=0, ADC_CSbar=1, ADC_SCK=0.
- Period counter:
  - Counts 0..DIV-1 while ENA=1 and wraps to 0.
  - Held at 0 while ENA=0.
  - A tick is the cycle in which the counter equals DIV-1.
- States:
  - IDLE: on a tick, go to CONV.
  - CONV: ADC_CONVST=1 for exactly CONV_CYC cycles, then go to READ.
  - READ: ADC_CSbar=0; generate BITS SCK pulses, each SCK_HALF cycles low then SCK_HALF cycles high. Sample ADC_SDO on the cycle SCK is driven 0→1. Shift MSB first. After the final high phase, drive SCK low and go to DONE.
  - DONE: ADC_CSbar=1. Load DOUT from the shift register. If FIFO_FULL=0, WR=1 for this cycle; otherwise WR=0 and DROPS increments (saturating). Return to IDLE.
- ENA dropping mid-frame: the current frame completes, including DONE. No further ticks are generated.
- A tick arriving while not IDLE cannot occur for legal DIV. It is ignored, with no other side effect.
- FIFO_FULL is sampled only in DONE. Its value at any other time has no effect.

## Timing
- The first tick occurs DIV cycles after ENA rises (counter at 0). Ticks then repeat every DIV cycles.
- From the tick cycle:
  - ADC_CONVST rises on the next edge and stays high CONV_CYC cycles.
  - ADC_CSbar falls on the edge that drops ADC_CONVST.
  - The READ phase lasts 2·SCK_HALF·BITS cycles.
  - DONE/WR follows one cycle after READ ends.
- Tick-to-WR latency is 1 + CONV_CYC + 2·SCK_HALF·BITS + 1 cycles, i.e. 106 cycles with the defaults.
- DOUT changes only on the DONE cycle and is stable for the whole WR cycle.
- WR is never high for two consecutive cycles.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
- ADC model returns 0xA5C3, FIFO_FULL=0, ENA held high for 3 periods: exactly 3 WR pulses, 128 cycles apart; DOUT=0xA5C3 at each pulse; the first WR is 106 cycles after the first tick.
- Per-frame waveform check: 40-cycle CONVST; 16 SCK pulses of period 4 cycles; CSbar low for 64 cycles; SCK low whenever CSbar=1. Model shifts 0x0001 then 0x8000; DOUT matches each (verifies MSB-first order).
- FIFO_FULL=1 for 5 periods, then 0: no WR during the full window, DROPS=5, DOUT still updates each frame, the next frame writes normally. Preload DROPS near 0xFFFF by forcing 70000 full frames (or a reduced-width test build): DROPS holds at 0xFFFF.
- ENA deasserted 20 cycles into READ: the frame completes with one WR carrying the correct data; no CONVST for the next 1000 cycles; on re-enable, the first tick comes exactly DIV cycles later.
- RSTbar pulsed low mid-READ with no SYS_CLK edge: outputs take reset values immediately (CSbar=1, SCK=0, DROPS=0, DOUT=0). After release with ENA=1, the first WR appears 128+106 cycles later.
- FIFO_FULL toggling every cycle throughout: WR is asserted iff FIFO_FULL=0 in the DONE cycle; DROPS equals the number of frames whose DONE cycle saw FIFO_FULL=1.

Source files
------------

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - paced serial ADC capture feeding the sample FIFO
module adc_sample_capture #(
  parameter int DIV      = 128,
  parameter int BITS     = 16,
  parameter int SCK_HALF = 2,
  parameter int CONV_CYC = 40,
  parameter int DROP_W   = 16
) (
  input  logic              SYS_CLK,
  input  logic              RSTbar,
  input  logic              ENA,
  input  logic              FIFO_FULL,
  input  logic              ADC_SDO,
  output logic              ADC_CONVST,
  output logic              ADC_CSbar,
  output logic              ADC_SCK,
  output logic [BITS-1:0]   DOUT,
  output logic              WR,
  output logic [DROP_W-1:0] DROPS,
  output logic              BUSY
);

  localparam int CW = $clog2(DIV + 1);
  localparam int PW = $clog2(CONV_CYC + 1);
  localparam int HW = $clog2(SCK_HALF + 1);
  localparam int BW = $clog2(BITS + 1);

  localparam logic [CW-1:0] PER_MAX  = CW'(DIV - 1);
  localparam logic [PW-1:0] CONV_MAX = PW'(CONV_CYC - 1);
  localparam logic [HW-1:0] HALF_MAX = HW'(SCK_HALF - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(BITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic            ena_q;
  logic [CW-1:0]   per_cnt;
  logic            tick;
  logic [PW-1:0]   conv_cnt;
  logic [HW-1:0]   half_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BITS-1:0] shreg;

  // ENA is registered so the first tick lands DIV cycles after it rises
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      ena_q   <= 1'b0;
      per_cnt <= '0;
    end else begin
      ena_q <= ENA;
      if (!ena_q || per_cnt == PER_MAX)
        per_cnt <= '0;
      else
        per_cnt <= per_cnt + 1'b1;
    end
  end

  assign tick = ena_q && (per_cnt == PER_MAX);

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      state      <= S_IDLE;
      ADC_CONVST <= 1'b0;
      ADC_CSbar  <= 1'b1;
      ADC_SCK    <= 1'b0;
      DOUT       <= '0;
      WR         <= 1'b0;
      DROPS      <= '0;
      BUSY       <= 1'b0;
      conv_cnt   <= '0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      WR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state      <= S_CONV;
            ADC_CONVST <= 1'b1;
            BUSY       <= 1'b1;
            conv_cnt   <= '0;
          end
        end
        S_CONV: begin
          if (conv_cnt == CONV_MAX) begin
            state      <= S_READ;
            ADC_CONVST <= 1'b0;
            ADC_CSbar  <= 1'b0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (half_cnt == HALF_MAX) begin
            half_cnt <= '0;
            // data is taken on the edge that raises SCK, MSB first
            if (!ADC_SCK) begin
              ADC_SCK <= 1'b1;
              shreg   <= {shreg[BITS-2:0], ADC_SDO};
            end else begin
              ADC_SCK <= 1'b0;
              if (bit_cnt == BIT_MAX) begin
                state     <= S_DONE;
                ADC_CSbar <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DOUT  <= shreg;
          if (!FIFO_FULL)
            WR <= 1'b1;
          else if (DROPS != '1)
            DROPS <= DROPS + 1'b1;
        end
      endcase
    end
  end

endmodule
